ss_edge_detect_multi: RTL

//  Multi-channel edge detector for asynchronous control inputs: buttons, start/stop strobes
//  and external handshakes feeding the sort engine.
//  Per channel: synchronises the input, debounces it and flags edges (rise/fall/both/none,

---
 rtl/ss_pkg.sv | 18 +
 rtl/ss_edge_channel.sv | 71 +++++++
 rtl/ss_edge_detect_multi.sv | 52 +++++
 3 files changed

// File: rtl/ss_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package ss_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } ss_edge_mode_e;

  // Debounce counter width; never narrower than one bit.
  function automatic int ss_cnt_w(int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ss_edge_channel.sv
// One channel: synchroniser, debounce counter, debounced level and edge pulse.
module ss_edge_channel
  import ss_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          signal_i,
  input  ss_edge_mode_e mode_i,
  output logic          level_o,
  output logic          pulse_o,
  output logic          qualify_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level_q, level_d;
  logic                   pulse_q;
  logic [1:0]             mode_bits;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign mode_bits = mode_i;

  if (DEBOUNCE_CNT == 0) begin : g_bypass
    assign level_d = synced;
  end else begin : g_debounce
    localparam int unsigned CntW = ss_cnt_w(DEBOUNCE_CNT);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (synced == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CNT - 1)) begin
        level_d = synced;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end
  end

  // Mode is looked at only on the edge where the level actually changes.
  always_comb begin
    qualify_o = (level_d & ~level_q & mode_bits[0]) | (~level_d & level_q & mode_bits[1]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], signal_i};
      level_q <= level_d;
      pulse_q <= qualify_o;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/ss_edge_detect_multi.sv
// Multi-channel edge detector with sticky pending bits and a masked interrupt.
module ss_edge_detect_multi
  import ss_pkg::*;
#(
  parameter int unsigned N_CH         = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH-1:0]   i_signal,
  input  logic [2*N_CH-1:0] i_mode,
  input  logic [N_CH-1:0]   i_clr,
  input  logic [N_CH-1:0]   i_irq_en,
  output logic [N_CH-1:0]   o_level,
  output logic [N_CH-1:0]   o_pulse,
  output logic [N_CH-1:0]   o_pending,
  output logic              o_irq
);

  logic [N_CH-1:0] qualify;
  logic [N_CH-1:0] pending_q, pending_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ss_edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_ch (
      .clk_i    (i_clk),
      .rst_ni   (i_rst_n),
      .signal_i (i_signal[k]),
      .mode_i   (ss_edge_mode_e'(i_mode[2*k +: 2])),
      .level_o  (o_level[k]),
      .pulse_o  (o_pulse[k]),
      .qualify_o(qualify[k])
    );
  end

  // Set wins over a same-cycle clear.
  always_comb begin
    pending_d = (pending_q & ~i_clr) | qualify;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign o_pending = pending_q;
  assign o_irq     = |(pending_q & i_irq_en);

endmodule
